// File: rtl/rs_station_pkg.sv
// -----------------------------------------------------------------------------
// rs_station_pkg
//
// Purpose: the shared configuration types for the reservation station and its
//          result unit. It provides the register and ROB-id types, the opcode
//          encodings, the slot layout, and the operand wakeup helper.
//          The register type is the REG_TYPE of the shared config, the ROB-id
//          type is its RO_BUFFER_ID_TYPE, and the opcode enum is its OP_TYPE.
//
// Contents:
//   reg_t        - 32-bit operand / result / PC value
//   rob_id_t     - reorder-buffer entry id (producer and destination tags)
//   op_t         - ALU / branch / jump opcode encodings
//   operand_t    - one source operand: ready flag, producer tag, value
//   broadcast_t  - one result broadcast (CDB or load bus)
//   slot_t       - one reservation slot
//   wake_operand - applies the CDB/LSB wakeup rules to one operand
// -----------------------------------------------------------------------------
package rs_station_pkg;

    localparam int XLEN     = 32;
    localparam int ROB_ID_W = 4;

    typedef logic [XLEN-1:0]     reg_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_LUI   = 5'd10,
        OP_AUIPC = 5'd11,
        OP_BEQ   = 5'd12,
        OP_BNE   = 5'd13,
        OP_BLT   = 5'd14,
        OP_BGE   = 5'd15,
        OP_BLTU  = 5'd16,
        OP_BGEU  = 5'd17,
        OP_JAL   = 5'd18,
        OP_JALR  = 5'd19
    } op_t;

    typedef struct packed {
        logic    rdy;
        rob_id_t tag;
        reg_t    val;
    } operand_t;

    typedef struct packed {
        logic    valid;
        rob_id_t dest;
        reg_t    value;
    } broadcast_t;

    typedef struct packed {
        logic     valid;
        op_t      op;
        operand_t rs1;
        operand_t rs2;
        reg_t     imm;
        reg_t     pc;
        rob_id_t  dest;
    } slot_t;

    // A waiting operand captures the broadcast value whose destination tag
    // matches its producer tag. The CDB is checked first, so it wins when both
    // buses carry the same tag. An operand that is already ready is never
    // overwritten.
    function automatic operand_t wake_operand(input operand_t   opnd,
                                              input broadcast_t cdb,
                                              input broadcast_t lsb);
        operand_t res;
        res = opnd;
        if (!opnd.rdy) begin
            if (cdb.valid && (cdb.dest == opnd.tag)) begin
                res.rdy = 1'b1;
                res.val = cdb.value;
            end else if (lsb.valid && (lsb.dest == opnd.tag)) begin
                res.rdy = 1'b1;
                res.val = lsb.value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_station_alu.sv
// -----------------------------------------------------------------------------
// rs_alu
//
// Purpose: a purely combinational result unit for the slot that the
//          reservation station has selected for dispatch. It produces the
//          architectural result value and the next PC. All arithmetic is
//          32-bit and wraps around.
//
// Ports:
//   op      in  opcode of the selected slot
//   rs1     in  first operand value
//   rs2     in  second operand value (shift amount is rs2[4:0])
//   imm     in  immediate
//   pc      in  instruction PC
//   value   out result value (the taken flag for branches, the link for jumps)
//   next_pc out PC of the next instruction on this path
// -----------------------------------------------------------------------------
module rs_alu
    import rs_station_pkg::*;
(
    input  op_t  op,
    input  reg_t rs1,
    input  reg_t rs2,
    input  reg_t imm,
    input  reg_t pc,
    output reg_t value,
    output reg_t next_pc
);

    reg_t pc_plus4;
    reg_t pc_plus_imm;
    logic taken;
    logic is_branch;

    assign pc_plus4    = pc + reg_t'(4);
    assign pc_plus_imm = pc + imm;

    // Conditional branches report the taken flag as their value and redirect
    // to pc+imm only when taken. Every non-control op falls through to pc+4.
    always_comb begin
        value     = '0;
        next_pc   = pc_plus4;
        taken     = 1'b0;
        is_branch = 1'b0;
        case (op)
            OP_ADD:   value = rs1 + rs2;
            OP_SUB:   value = rs1 - rs2;
            OP_AND:   value = rs1 & rs2;
            OP_OR:    value = rs1 | rs2;
            OP_XOR:   value = rs1 ^ rs2;
            OP_SLL:   value = rs1 << rs2[4:0];
            OP_SRL:   value = rs1 >> rs2[4:0];
            OP_SRA:   value = reg_t'($signed(rs1) >>> rs2[4:0]);
            OP_SLT:   value = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            OP_SLTU:  value = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
            OP_LUI:   value = imm;
            OP_AUIPC: value = pc_plus_imm;
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = (rs1 == rs2);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = (rs1 != rs2);
            end
            OP_BLT: begin
                is_branch = 1'b1;
                taken     = ($signed(rs1) < $signed(rs2));
            end
            OP_BGE: begin
                is_branch = 1'b1;
                taken     = ($signed(rs1) >= $signed(rs2));
            end
            OP_BLTU: begin
                is_branch = 1'b1;
                taken     = (rs1 < rs2);
            end
            OP_BGEU: begin
                is_branch = 1'b1;
                taken     = (rs1 >= rs2);
            end
            OP_JAL: begin
                value   = pc_plus4;
                next_pc = pc_plus_imm;
            end
            OP_JALR: begin
                value   = pc_plus4;
                next_pc = (rs1 + imm) & ~reg_t'(1);
            end
            default: ;
        endcase
        if (is_branch) begin
            value   = {{(XLEN-1){1'b0}}, taken};
            next_pc = taken ? pc_plus_imm : pc_plus4;
        end
    end

endmodule

// File: rtl/rs_station.sv
// -----------------------------------------------------------------------------
// rs_station
//
// Purpose: an ALU/branch reservation station with ENTRIES slots. Instructions
//          are issued into the lowest-index free slot. Waiting operands are
//          woken by CDB and load-bus broadcasts. Each cycle the lowest-index
//          slot whose operands were both ready at cycle start is dispatched,
//          and its result is registered onto the out_* port.
//
// Configuration macro: RS_PERF_EN adds the perf_dispatched and
//          perf_full_stall counters. The default build omits them.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   rdy                   global enable; all state holds while low
//   flush                 misprediction clear; drops every slot and the output
//   issue_*               one incoming instruction with its operands and tags
//   full                  combinational flag: no free slot
//   cdb_*, lsb_*          result broadcasts used for wakeup
//   out_valid/dest/value/next_pc  registered dispatch result (one cycle pulse)
//   perf_dispatched       (RS_PERF_EN) dispatch count
//   perf_full_stall       (RS_PERF_EN) count of cycles with issue_valid && full
// -----------------------------------------------------------------------------
module rs_station
    import rs_station_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    rdy,
    input  logic    flush,
    input  logic    issue_valid,
    input  op_t     issue_op,
    input  reg_t    issue_rs1_val,
    input  reg_t    issue_rs2_val,
    input  rob_id_t issue_rs1_tag,
    input  rob_id_t issue_rs2_tag,
    input  logic    issue_rs1_rdy,
    input  logic    issue_rs2_rdy,
    input  reg_t    issue_imm,
    input  reg_t    issue_pc,
    input  rob_id_t issue_dest,
    output logic    full,
    input  logic    cdb_valid,
    input  rob_id_t cdb_dest,
    input  reg_t    cdb_value,
    input  logic    lsb_valid,
    input  rob_id_t lsb_dest,
    input  reg_t    lsb_value,
    output logic    out_valid,
    output rob_id_t out_dest,
    output reg_t    out_value,
    output reg_t    out_next_pc
`ifdef RS_PERF_EN
    ,
    output logic [31:0] perf_dispatched,
    output logic [31:0] perf_full_stall
`endif
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    slot_t   slots_q [ENTRIES];
    slot_t   slots_d [ENTRIES];
    logic    out_valid_q,   out_valid_d;
    rob_id_t out_dest_q,    out_dest_d;
    reg_t    out_value_q,   out_value_d;
    reg_t    out_next_pc_q, out_next_pc_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic             issue_accept;
    reg_t             alu_value;
    reg_t             alu_next_pc;
    operand_t         issue_rs1_opnd;
    operand_t         issue_rs2_opnd;
    broadcast_t       cdb_bc;
    broadcast_t       lsb_bc;

    assign cdb_bc         = '{valid: cdb_valid, dest: cdb_dest, value: cdb_value};
    assign lsb_bc         = '{valid: lsb_valid, dest: lsb_dest, value: lsb_value};
    assign issue_rs1_opnd = '{rdy: issue_rs1_rdy, tag: issue_rs1_tag, val: issue_rs1_val};
    assign issue_rs2_opnd = '{rdy: issue_rs2_rdy, tag: issue_rs2_tag, val: issue_rs2_val};

    // The scan runs from the top index down, so the last hit is the lowest
    // index. Dispatch looks only at the registered ready bits, which keeps a
    // slot woken this cycle from dispatching before the next one.
    always_comb begin
        full      = 1'b1;
        free_idx  = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!slots_q[i].valid) begin
                full     = 1'b0;
                free_idx = IDX_W'(i);
            end
            if (slots_q[i].valid && slots_q[i].rs1.rdy && slots_q[i].rs2.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue is decided against the occupancy at cycle start. A slot freed by
    // this cycle's dispatch cannot take this cycle's issue.
    assign issue_accept = issue_valid && !full && !flush;

    rs_alu u_alu (
        .op      (slots_q[sel_idx].op),
        .rs1     (slots_q[sel_idx].rs1.val),
        .rs2     (slots_q[sel_idx].rs2.val),
        .imm     (slots_q[sel_idx].imm),
        .pc      (slots_q[sel_idx].pc),
        .value   (alu_value),
        .next_pc (alu_next_pc)
    );

    // Flush beats issue, wakeup and dispatch. Otherwise all three can happen
    // together, because the issue slot is free and the dispatch slot is
    // occupied, so they never collide.
    always_comb begin
        slots_d       = slots_q;
        out_valid_d   = out_valid_q;
        out_dest_d    = out_dest_q;
        out_value_d   = out_value_q;
        out_next_pc_d = out_next_pc_q;
        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    slots_d[i].valid = 1'b0;
                end
                out_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (slots_q[i].valid) begin
                        slots_d[i].rs1 = wake_operand(slots_q[i].rs1, cdb_bc, lsb_bc);
                        slots_d[i].rs2 = wake_operand(slots_q[i].rs2, cdb_bc, lsb_bc);
                    end
                end
                out_valid_d = sel_found;
                if (sel_found) begin
                    slots_d[sel_idx].valid = 1'b0;
                    out_dest_d             = slots_q[sel_idx].dest;
                    out_value_d            = alu_value;
                    out_next_pc_d          = alu_next_pc;
                end
                if (issue_accept) begin
                    slots_d[free_idx].valid = 1'b1;
                    slots_d[free_idx].op    = issue_op;
                    slots_d[free_idx].rs1   = wake_operand(issue_rs1_opnd, cdb_bc, lsb_bc);
                    slots_d[free_idx].rs2   = wake_operand(issue_rs2_opnd, cdb_bc, lsb_bc);
                    slots_d[free_idx].imm   = issue_imm;
                    slots_d[free_idx].pc    = issue_pc;
                    slots_d[free_idx].dest  = issue_dest;
                end
            end
        end
    end

    // Reset clears the slots and the output. It takes precedence over rdy
    // and flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slots_q[i] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_dest_q    <= '0;
            out_value_q   <= '0;
            out_next_pc_q <= '0;
        end else begin
            slots_q       <= slots_d;
            out_valid_q   <= out_valid_d;
            out_dest_q    <= out_dest_d;
            out_value_q   <= out_value_d;
            out_next_pc_q <= out_next_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_dest    = out_dest_q;
    assign out_value   = out_value_q;
    assign out_next_pc = out_next_pc_q;

`ifdef RS_PERF_EN
    logic [31:0] perf_dispatched_q, perf_dispatched_d;
    logic [31:0] perf_full_stall_q, perf_full_stall_d;

    // Both counters freeze with rdy low and wrap naturally. Flush does not
    // clear them. A flush cycle has no dispatch, so nothing is counted then.
    always_comb begin
        perf_dispatched_d = perf_dispatched_q;
        perf_full_stall_d = perf_full_stall_q;
        if (rdy) begin
            if (!flush && sel_found) begin
                perf_dispatched_d = perf_dispatched_q + 32'd1;
            end
            if (issue_valid && full) begin
                perf_full_stall_d = perf_full_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_dispatched_q <= '0;
            perf_full_stall_q <= '0;
        end else begin
            perf_dispatched_q <= perf_dispatched_d;
            perf_full_stall_q <= perf_full_stall_d;
        end
    end

    assign perf_dispatched = perf_dispatched_q;
    assign perf_full_stall = perf_full_stall_q;
`endif

endmodule

// File: tb/tb_rs_station.sv
// -----------------------------------------------------------------------------
// tb_rs_station
//
// Drives rs_station with directed scenarios and then randomized traffic. The
// station is tracked by a slot-list reference model, and results are computed
// from the instruction semantics.
// -----------------------------------------------------------------------------
module tb_rs_station;
   import rs_station_pkg::*;

   localparam int ENTRIES = 8;

   logic    clk = 1'b0;
   logic    rst_n, rdy, flush, issue_valid;
   op_t     issue_op;
   reg_t    issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
   rob_id_t issue_rs1_tag, issue_rs2_tag, issue_dest;
   logic    issue_rs1_rdy, issue_rs2_rdy;
   logic    full;
   logic    cdb_valid, lsb_valid;
   rob_id_t cdb_dest, lsb_dest;
   reg_t    cdb_value, lsb_value;
   logic    out_valid;
   rob_id_t out_dest;
   reg_t    out_value, out_next_pc;

   always #5 clk = ~clk;

   rs_station #(.ENTRIES(ENTRIES)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
      .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
      .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
      .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_dest(issue_dest),
      .full(full),
      .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
      .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
      .out_valid(out_valid), .out_dest(out_dest), .out_value(out_value),
      .out_next_pc(out_next_pc)
   );

   int checks = 0;
   int passes = 0;

   // Reference model: one record per slot plus the registered output.
   typedef struct {
      bit      valid;
      op_t     op;
      bit      r1, r2;
      rob_id_t t1, t2;
      reg_t    v1, v2, imm, pc;
      rob_id_t dest;
   } mslot_t;

   mslot_t  ms [ENTRIES];
   bit      mOutValid;
   rob_id_t mOutDest;
   reg_t    mOutValue, mOutNextPc;

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
   endtask

   // Instruction semantics, written directly from the ISA rules.
   function automatic void computeExpected(input mslot_t s, output reg_t val, output reg_t npc);
      reg_t a, b;
      int   sh;
      bit   br, tk;
      a   = s.v1;
      b   = s.v2;
      sh  = int'(b[4:0]);
      val = 0;
      npc = s.pc + 4;
      br  = 0;
      tk  = 0;
      case (s.op)
         OP_ADD:   val = a + b;
         OP_SUB:   val = a - b;
         OP_AND:   val = a & b;
         OP_OR:    val = a | b;
         OP_XOR:   val = a ^ b;
         OP_SLL:   val = a << sh;
         OP_SRL:   val = a >> sh;
         OP_SRA:   val = $unsigned($signed(a) >>> sh);
         OP_SLT:   val = ($signed(a) < $signed(b)) ? 1 : 0;
         OP_SLTU:  val = (a < b) ? 1 : 0;
         OP_LUI:   val = s.imm;
         OP_AUIPC: val = s.pc + s.imm;
         OP_BEQ:   begin br = 1; tk = (a == b); end
         OP_BNE:   begin br = 1; tk = (a != b); end
         OP_BLT:   begin br = 1; tk = ($signed(a) < $signed(b)); end
         OP_BGE:   begin br = 1; tk = ($signed(a) >= $signed(b)); end
         OP_BLTU:  begin br = 1; tk = (a < b); end
         OP_BGEU:  begin br = 1; tk = (a >= b); end
         OP_JAL:   begin val = s.pc + 4; npc = s.pc + s.imm; end
         OP_JALR:  begin val = s.pc + 4; npc = (a + s.imm) & 32'hFFFF_FFFE; end
         default: ;
      endcase
      if (br) begin
         val = tk ? 1 : 0;
         npc = tk ? s.pc + s.imm : s.pc + 4;
      end
   endfunction

   // Returns 1 when a broadcast carries tag t; the CDB takes precedence.
   function automatic bit bcastHit(input rob_id_t t, output reg_t v);
      v = 0;
      if (cdb_valid && cdb_dest == t) begin v = cdb_value; return 1; end
      if (lsb_valid && lsb_dest == t) begin v = lsb_value; return 1; end
      return 0;
   endfunction

   function automatic bit mFull();
      for (int i = 0; i < ENTRIES; i++) if (!ms[i].valid) return 0;
      return 1;
   endfunction

   // Advances the model by one clock edge, using the inputs held across it.
   task automatic modelStep();
      int     sel, fr;
      reg_t   v, ev, en;
      mslot_t ns;
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) ms[i].valid = 0;
         mOutValid = 0; mOutDest = 0; mOutValue = 0; mOutNextPc = 0;
         return;
      end
      if (!rdy) return;
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) ms[i].valid = 0;
         mOutValid = 0;
         return;
      end
      sel = -1;
      fr  = -1;
      for (int i = 0; i < ENTRIES; i++) begin
         if (sel < 0 && ms[i].valid && ms[i].r1 && ms[i].r2) sel = i;
         if (fr < 0 && !ms[i].valid) fr = i;
      end
      if (sel >= 0) begin
         computeExpected(ms[sel], ev, en);
         mOutValid = 1; mOutDest = ms[sel].dest; mOutValue = ev; mOutNextPc = en;
         ms[sel].valid = 0;
      end else begin
         mOutValid = 0;
      end
      for (int i = 0; i < ENTRIES; i++) begin
         if (ms[i].valid) begin
            if (!ms[i].r1 && bcastHit(ms[i].t1, v)) begin ms[i].r1 = 1; ms[i].v1 = v; end
            if (!ms[i].r2 && bcastHit(ms[i].t2, v)) begin ms[i].r2 = 1; ms[i].v2 = v; end
         end
      end
      if (issue_valid && fr >= 0) begin
         ns.valid = 1; ns.op = issue_op; ns.imm = issue_imm; ns.pc = issue_pc; ns.dest = issue_dest;
         ns.r1 = issue_rs1_rdy; ns.t1 = issue_rs1_tag; ns.v1 = issue_rs1_val;
         ns.r2 = issue_rs2_rdy; ns.t2 = issue_rs2_tag; ns.v2 = issue_rs2_val;
         if (!ns.r1 && bcastHit(ns.t1, v)) begin ns.r1 = 1; ns.v1 = v; end
         if (!ns.r2 && bcastHit(ns.t2, v)) begin ns.r2 = 1; ns.v2 = v; end
         ms[fr] = ns;
      end
   endtask

   task automatic checkAgainstModel();
      checkOutput("full", 32'(full), 32'(mFull()));
      checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
      if (mOutValid) begin
         checkOutput("out_dest", 32'(out_dest), 32'(mOutDest));
         checkOutput("out_value", out_value, mOutValue);
         checkOutput("out_next_pc", out_next_pc, mOutNextPc);
      end
   endtask

   // One clock: the edge updates the DUT and the model, and the falling edge
   // compares them.
   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkAgainstModel();
   endtask

   task automatic idleInputs();
      rst_n = 1; rdy = 1; flush = 0; issue_valid = 0; issue_op = OP_ADD;
      issue_rs1_val = 0; issue_rs2_val = 0; issue_rs1_tag = 0; issue_rs2_tag = 0;
      issue_rs1_rdy = 1; issue_rs2_rdy = 1; issue_imm = 0; issue_pc = 0; issue_dest = 0;
      cdb_valid = 0; cdb_dest = 0; cdb_value = 0;
      lsb_valid = 0; lsb_dest = 0; lsb_value = 0;
   endtask

   task automatic applyStimulus(input op_t op, input reg_t a, input bit ra, input rob_id_t ta,
                                input reg_t b, input bit rb, input rob_id_t tb,
                                input reg_t imm, input reg_t pc, input rob_id_t dest);
      issue_valid = 1; issue_op = op;
      issue_rs1_val = a; issue_rs1_rdy = ra; issue_rs1_tag = ta;
      issue_rs2_val = b; issue_rs2_rdy = rb; issue_rs2_tag = tb;
      issue_imm = imm; issue_pc = pc; issue_dest = dest;
   endtask

   initial begin
      for (int i = 0; i < ENTRIES; i++) ms[i].valid = 0;
      mOutValid = 0; mOutDest = 0; mOutValue = 0; mOutNextPc = 0;
      idleInputs();
      rst_n = 0;
      @(negedge clk);
      tick();
      tick();
      checkOutput("rst_full", 32'(full), 0);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_out_dest", 32'(out_dest), 0);
      checkOutput("rst_out_value", out_value, 0);
      checkOutput("rst_out_next_pc", out_next_pc, 0);
      rst_n = 1;

      // Operands ready at issue: result appears on the second edge.
      applyStimulus(OP_ADD, 5, 1, 0, 7, 1, 0, 0, 32'h40, 3);
      tick();
      issue_valid = 0;
      checkOutput("add_not_yet", 32'(out_valid), 0);
      tick();
      checkOutput("add_valid", 32'(out_valid), 1);
      checkOutput("add_dest", 32'(out_dest), 3);
      checkOutput("add_value", out_value, 12);
      checkOutput("add_next_pc", out_next_pc, 32'h44);
      tick();
      checkOutput("add_one_pulse", 32'(out_valid), 0);

      // Wakeup of a stored slot and of a same-cycle issue on tag 6.
      applyStimulus(OP_SUB, 0, 0, 6, 8, 1, 0, 0, 32'h80, 1);
      tick();
      applyStimulus(OP_SUB, 0, 0, 6, 3, 1, 0, 0, 32'h90, 2);
      cdb_valid = 1; cdb_dest = 6; cdb_value = 20;
      tick();
      idleInputs();
      checkOutput("wake_not_yet", 32'(out_valid), 0);
      tick();
      checkOutput("wake_valid", 32'(out_valid), 1);
      checkOutput("wake_dest", 32'(out_dest), 1);
      checkOutput("wake_value", out_value, 12);
      tick();
      checkOutput("wake_issue_dest", 32'(out_dest), 2);
      checkOutput("wake_issue_value", out_value, 17);
      tick();

      // Fill all slots, drop a ninth issue, then drain one slot via the load bus.
      for (int k = 0; k < ENTRIES; k++) begin
         applyStimulus(OP_ADD, 0, 0, rob_id_t'(k + 1), reg_t'(k), 1, 0, 0, 32'h200, rob_id_t'(k));
         tick();
      end
      checkOutput("fill_full", 32'(full), 1);
      applyStimulus(OP_ADD, 1, 1, 0, 1, 1, 0, 0, 32'h300, 15);
      tick();
      checkOutput("fill_still_full", 32'(full), 1);
      idleInputs();
      lsb_valid = 1; lsb_dest = 1; lsb_value = 100;
      tick();
      idleInputs();
      checkOutput("fill_woken_full", 32'(full), 1);
      tick();
      checkOutput("fill_drained", 32'(full), 0);
      checkOutput("fill_out_value", out_value, 100);
      flush = 1;
      tick();
      idleInputs();

      // Branch and indirect jump.
      applyStimulus(OP_BNE, 1, 1, 0, 2, 1, 0, 32'h20, 32'h100, 4);
      tick();
      applyStimulus(OP_JALR, 32'h203, 1, 0, 0, 1, 0, 1, 32'h300, 5);
      tick();
      idleInputs();
      checkOutput("bne_value", out_value, 1);
      checkOutput("bne_next_pc", out_next_pc, 32'h120);
      tick();
      checkOutput("jalr_value", out_value, 32'h304);
      checkOutput("jalr_next_pc", out_next_pc, 32'h204);
      tick();

      // Flush with four occupied slots (one ready to dispatch) plus an issue.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(OP_OR, 0, 0, rob_id_t'(k + 1), 1, 1, 0, 0, 0, rob_id_t'(k));
         tick();
      end
      applyStimulus(OP_ADD, 2, 1, 0, 2, 1, 0, 0, 0, 9);
      tick();
      applyStimulus(OP_ADD, 3, 1, 0, 3, 1, 0, 0, 0, 10);
      flush = 1;
      cdb_valid = 1; cdb_dest = 1; cdb_value = 7;
      tick();
      idleInputs();
      checkOutput("flush_full", 32'(full), 0);
      checkOutput("flush_out_valid", 32'(out_valid), 0);
      for (int k = 2; k < 5; k++) begin
         cdb_valid = 1; cdb_dest = rob_id_t'(k); cdb_value = 1;
         tick();
         checkOutput("flush_quiet", 32'(out_valid), 0);
      end
      idleInputs();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         rdy   = ($urandom_range(0, 7) != 0);
         flush = ($urandom_range(0, 39) == 0);
         issue_valid   = ($urandom_range(0, 9) < 6);
         issue_op      = op_t'($urandom_range(0, 19));
         issue_rs1_val = ($urandom_range(0, 1) != 0) ? reg_t'($urandom_range(0, 3)) : reg_t'($urandom);
         issue_rs2_val = ($urandom_range(0, 1) != 0) ? reg_t'($urandom_range(0, 3)) : reg_t'($urandom);
         issue_rs1_rdy = ($urandom_range(0, 1) != 0);
         issue_rs2_rdy = ($urandom_range(0, 1) != 0);
         issue_rs1_tag = rob_id_t'($urandom_range(0, 7));
         issue_rs2_tag = rob_id_t'($urandom_range(0, 7));
         issue_imm     = reg_t'($urandom);
         issue_pc      = reg_t'($urandom);
         issue_dest    = rob_id_t'($urandom);
         cdb_valid     = ($urandom_range(0, 2) == 0);
         cdb_dest      = rob_id_t'($urandom_range(0, 7));
         cdb_value     = reg_t'($urandom);
         lsb_valid     = ($urandom_range(0, 2) == 0);
         lsb_dest      = rob_id_t'($urandom_range(0, 7));
         lsb_value     = reg_t'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rs_station.md
RS_STATION -- requirements
Module: rs_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, meaning number of reservation slots (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port rdy, input, 1, global enable; when low, all state holds.
REQ-005 SHALL have port flush, input, 1, misprediction clear from ro_buffer.
REQ-006 SHALL have port issue_valid, input, 1, issuer presents one instruction.
REQ-007 SHALL have port issue_op, input, `OP_TYPE`, ALU/branch opcode.
REQ-008 SHALL have ports issue_rs1_val and issue_rs2_val, input, `REG_TYPE`, operand values.
REQ-009 SHALL have ports issue_rs1_tag and issue_rs2_tag, input, `RO_BUFFER_ID_TYPE`, producer ROB id.
REQ-010 SHALL have ports issue_rs1_rdy and issue_rs2_rdy, input, 1, operand value valid.
REQ-011 SHALL have ports issue_imm and issue_pc, input, `REG_TYPE`, immediate and instruction PC.
REQ-012 SHALL have port issue_dest, input, `RO_BUFFER_ID_TYPE`, destination ROB id.
REQ-013 SHALL have port full, output, 1, no free slot.
REQ-014 SHALL have ports cdb_valid, cdb_dest, cdb_value, input, 1/`RO_BUFFER_ID_TYPE`/`REG_TYPE`, broadcast returned from rss_bus.
REQ-015 SHALL have ports lsb_valid, lsb_dest, lsb_value, input, 1/`RO_BUFFER_ID_TYPE`/`REG_TYPE`, load result broadcast.
REQ-016 SHALL have ports out_valid, out_dest, out_value, out_next_pc, output, 1/`RO_BUFFER_ID_TYPE`/`REG_TYPE`/`REG_TYPE`, result driven into rss_bus.

Function
REQ-017 SHALL accept an issue when issue_valid && !full && !flush, writing the lowest-index free slot.
REQ-018 SHALL assert full combinationally when every slot is occupied; an issue while full SHALL be dropped.
REQ-019 SHALL, for every occupied waiting operand whose tag equals cdb_dest (cdb_valid) or lsb_dest (lsb_valid), capture the value and mark it ready at the clock edge.
REQ-020 SHALL apply the same wakeup to operands arriving on the issue port in that cycle.
REQ-021 SHALL, if both broadcasts match one tag, take the cdb value.
REQ-022 SHALL each cycle select the lowest-index slot with both operands ready at cycle start, free it, and register its result; latency from "both ready" to out_valid is exactly 1 cycle.
REQ-023 SHALL NOT dispatch a slot that was woken in the current cycle; it dispatches no earlier than the next cycle.
REQ-024 SHALL hold out_valid high for exactly one cycle per dispatch, low otherwise; out_dest/out_value/out_next_pc are don't-care when low.
REQ-025 SHALL compute in 32-bit wrap-around arithmetic: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shamt = rs2[4:0]), SLT, SLTU, LUI (value=imm), AUIPC (value=pc+imm).
REQ-026 SHALL set next_pc = pc+4 for non-control ops.
REQ-027 SHALL, for BEQ/BNE/BLT/BGE/BLTU/BGEU, set value=taken (0/1) and next_pc=taken ? pc+imm : pc+4.
REQ-028 SHALL, for JAL, set value=pc+4 and next_pc=pc+imm; for JALR, set value=pc+4 and next_pc=(rs1+imm)&~1.
REQ-029 SHALL, on flush, invalidate all slots and clear out_valid on the next edge; flush overrides any simultaneous issue, wakeup and dispatch.
REQ-030 SHALL support issue, wakeup and dispatch in the same cycle, including freeing a slot and reusing it in the same cycle only when another slot is free (no same-slot bypass).

Reset
REQ-031 SHALL, on a clk edge with rst_n low, clear all slot valid bits, out_valid=0, out_dest=0, out_value=0 and out_next_pc=0; rst_n takes priority over rdy and flush.
REQ-032 SHALL, when reset is asserted mid-operation, discard in-flight slots with no output.

Configuration
REQ-033 SHALL, with RS_PERF_EN defined, expose outputs perf_dispatched and perf_full_stall, 32-bit each: counts of dispatches and of cycles with issue_valid && full; both reset to 0, wrap, and keep counting across flush.
REQ-034 SHALL, without RS_PERF_EN, have neither port nor counters.

Structure
REQ-035 SHALL take `OP_TYPE`, the opcode encodings, `REG_TYPE` and `RO_BUFFER_ID_TYPE` from shared config.v.
REQ-036 SHALL place result/next_pc computation in the combinational sub-module rs_alu, instantiated once on the selected slot.

Verification
REQ-037 Reset: rst_n=0 for 2 cycles -> full=0, out_valid=0, all outputs 0.
REQ-038 Ready issue: ADD rs1=5, rs2=7, dest=3, both ready -> slot taken, next cycle no output yet, following cycle out_valid=1, dest=3, value=12, next_pc=pc+4.
REQ-039 Wakeup: SUB waiting on tag 6; cdb_valid, dest=6, value=20 with rs2=8 -> out_value=12 two cycles after broadcast; a same-cycle issue with tag 6 is also woken.
REQ-040 Fill/stall: 8 issues with unready operands -> full=1; a 9th is dropped; one wakeup -> dispatch, full drops to 0.
REQ-041 Branch: BNE rs1=1, rs2=2, pc=0x100, imm=0x20 -> value=1, next_pc=0x120; JALR rs1=0x203, imm=1 -> next_pc=0x204, value=pc+4.
REQ-042 Flush: flush with 4 occupied slots plus a simultaneous issue -> next cycle full=0, no out_valid thereafter until a new issue.
